// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential fetch issuer with DEPTH in-flight credits, in-order response FIFO toward decode, flush discards stale beats
module ifu_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [DATA_W-1:0] inst_data_o,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] fetch_pc, rsp_pc, flush_pc;
  logic [CW-1:0] count, outst, discard;
  logic [CW:0] occ, inflight;
  logic [PW-1:0] head, tail;
  logic init, fire, live, drop, pop, push;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  always_comb begin
    occ = {1'b0, count} + {1'b0, outst};
    inflight = {1'b0, outst} + {1'b0, discard};
    req_valid_o = !rst && !flush_i && !init && occ < (CW+1)'(DEPTH) && inflight < (CW+1)'(DEPTH);
    req_addr_o = fetch_pc;
    fire = req_valid_o && req_ready_i;
    drop = rsp_valid_i && discard != '0;
    live = rsp_valid_i && discard == '0 && outst != '0;
    inst_valid_o = !rst && count != '0;
    pop = inst_valid_o && inst_ready_i;
    push = live && !flush_i && !rst;
    flush_pc = flush_pc_i & ~ADDR_W'(3);
    inst_pc_o = pc_q[head];
    inst_data_o = data_q[head];
  end
  always_ff @(posedge clk)
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      count <= '0;
      outst <= '0;
      discard <= '0;
      head <= '0;
      tail <= '0;
      init <= 1'b1;
    end else if (flush_i) begin
      init <= 1'b0;
      fetch_pc <= flush_pc;
      rsp_pc <= flush_pc;
      count <= '0;
      outst <= '0;
      head <= '0;
      tail <= '0;
      discard <= discard + outst - CW'(drop || live);
    end else begin
      init <= 1'b0;
      fetch_pc <= fire ? fetch_pc + ADDR_W'(4) : fetch_pc;
      rsp_pc <= live ? rsp_pc + ADDR_W'(4) : rsp_pc;
      count <= count + CW'(live) - CW'(pop);
      outst <= outst + CW'(fire) - CW'(live);
      discard <= discard - CW'(drop);
      head <= head + PW'(pop);
      tail <= tail + PW'(live);
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[tail] <= rsp_pc;
      data_q[tail] <= rsp_data_i;
    end
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) !(rsp_valid_i && outst == '0 && discard == '0));
  a_inflight_cap: assert property (@(posedge clk) disable iff (rst) inflight <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: randomized and directed checks of ifu_prefetch against a queue-based fetch/memory/decode model
module tb_ifu_prefetch;
  localparam int DEPTH = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, req_valid_o, req_ready_i = 0, rsp_valid_i = 0, inst_valid_o, inst_ready_i = 0, flush_i = 0;
  logic [31:0] req_addr_o, rsp_data_i = '0, inst_pc_o, inst_data_o, flush_pc_i = '0;
  logic w_req_valid, w_rsp_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_inst_pc, w_inst_data;
  ifu_prefetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_pc_o(inst_pc_o), .inst_data_o(inst_data_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i)
  );
  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .req_valid_o(w_req_valid), .req_ready_i(1'b1), .req_addr_o(w_req_addr),
    .rsp_valid_i(w_rsp_valid), .rsp_data_i(w_rsp_data),
    .inst_valid_o(w_inst_valid), .inst_ready_i(1'b1), .inst_pc_o(w_inst_pc), .inst_data_o(w_inst_data),
    .flush_i(1'b0), .flush_pc_i(32'h0)
  );
  always_ff @(posedge clk) begin
    w_rsp_valid <= !rst && w_req_valid;
    w_rsp_data <= w_req_addr;
  end
  typedef struct {logic [31:0] a; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
  mreq_t mq[$];
  ent_t rq[$];
  logic [31:0] pcq[$], qa[$], qp[$], qd[$];
  int checks = 0, errors = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, fires = 0;
  bit r_rst = 1, r_flush = 0, r_ready = 0, r_iready = 0, first = 1, t5_on = 0, got;
  logic [31:0] r_fpc = '0, exp_pc = '0;
  logic [31:0] exp5 [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  function automatic logic [31:0] data_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(string tag, logic [31:0] got_v, logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask
  task automatic step();
    bit resp, ev, stale;
    int d;
    logic [31:0] pc;
    @(negedge clk);
    rst = r_rst;
    flush_i = r_flush;
    flush_pc_i = r_fpc;
    req_ready_i = r_ready;
    inst_ready_i = r_iready;
    resp = 0;
    if (mq.size() > 0) resp = mq[0].due <= cyc;
    rsp_valid_i = resp;
    rsp_data_i = $urandom;
    if (resp) rsp_data_i = data_of(mq[0].a);
    #1;
    ev = !r_rst && !r_flush && !first && rq.size() + pcq.size() < DEPTH && mq.size() < DEPTH;
    chk("req_valid", 32'(req_valid_o), 32'(ev));
    if (ev) chk("req_addr", req_addr_o, exp_pc);
    chk("inst_valid", 32'(inst_valid_o), 32'(!r_rst && rq.size() > 0));
    if (!r_rst && rq.size() > 0) begin
      chk("inst_pc", inst_pc_o, rq[0].pc);
      chk("inst_data", inst_data_o, rq[0].d);
    end
    if (t5_on) begin
      if (w_req_valid) qa.push_back(w_req_addr);
      if (w_inst_valid) begin
        qp.push_back(w_inst_pc);
        qd.push_back(w_inst_data);
      end
    end
    if (req_valid_o && req_ready_i) fires++;
    if (r_rst) begin
      mq.delete();
      rq.delete();
      pcq.delete();
      exp_pc = 32'h0;
      first = 1;
    end else begin
      first = 0;
      if (r_iready && !r_flush && rq.size() > 0) rq.delete(0);
      if (resp) begin
        stale = mq.size() > pcq.size();
        mq.delete(0);
        if (!stale) begin
          pc = pcq.pop_front();
          if (!r_flush) rq.push_back('{pc, data_of(pc)});
        end
      end
      if (r_flush) begin
        rq.delete();
        pcq.delete();
        exp_pc = {r_fpc[31:2], 2'b00};
      end
      if (ev && r_ready) begin
        d = cyc + $urandom_range(lat_hi, lat_lo);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{req_addr_o, d});
        pcq.push_back(exp_pc);
        exp_pc += 4;
      end
    end
    cyc++;
  endtask
  task automatic do_reset();
    r_rst = 1;
    r_flush = 0;
    repeat (3) step();
    r_rst = 0;
  endtask
  initial begin
    r_ready = 1;
    r_iready = 1;
    do_reset();
    t5_on = 1;
    repeat (12) step();
    t5_on = 0;
    chk("t5_count", 32'(qa.size() >= 3 && qp.size() >= 3), 32'd1);
    if (qa.size() >= 3 && qp.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk("t5_addr", qa[i], exp5[i]);
        chk("t5_pc", qp[i], exp5[i]);
        chk("t5_data", qd[i], exp5[i]);
      end
    r_iready = 0;
    do_reset();
    fires = 0;
    repeat (10) step();
    chk("t2_fires", fires, 32'd4);
    chk("t2_req_valid", 32'(req_valid_o), 32'd0);
    chk("t2_head", inst_pc_o, 32'h0);
    r_iready = 1;
    repeat (12) step();
    lat_lo = 5;
    lat_hi = 5;
    do_reset();
    fires = 0;
    for (int i = 0; i < 10 && fires < 3; i++) step();
    r_ready = 0;
    r_flush = 1;
    r_fpc = 32'h103;
    step();
    r_flush = 0;
    r_ready = 1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (inst_valid_o) begin
        got = 1;
        break;
      end
    end
    chk("t3_seen", 32'(got), 32'd1);
    if (got) begin
      chk("t3_pc", inst_pc_o, 32'h100);
      chk("t3_data", inst_data_o, data_of(32'h100));
    end
    lat_lo = 1;
    lat_hi = 1;
    r_iready = 0;
    do_reset();
    for (int i = 0; i < 10 && rq.size() == 0; i++) step();
    r_flush = 1;
    r_iready = 1;
    r_fpc = 32'h200;
    step();
    chk("t4_req_valid", 32'(req_valid_o), 32'd0);
    r_flush = 0;
    step();
    chk("t4_empty", 32'(inst_valid_o), 32'd0);
    repeat (15) step();
    lat_hi = 6;
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      r_rst = $urandom_range(1999, 0) == 0;
      r_flush = $urandom_range(29, 0) == 0;
      r_fpc = $urandom;
      r_ready = $urandom_range(9, 0) < 7;
      r_iready = $urandom_range(9, 0) < 6;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
